operand_fetch: RTL
==================

# operand_fetch

Operand-fetch/issue stage sitting directly upstream of the combinational MIPS ALU. Holds the 32×32 architectural register file and accepts decoded-format MIPS instructions over a valid/ready handshake. Reads the rs/rt operands, tracks in-flight destinations with a one-bit-per-register scoreboard, and stalls on hazards. Presents a registered instruction/operand pair in the form the ALU consumes: rs field rewritten to 0 (selects regA), rt field rewritten to 1 (selects regB).

## Interface

Parameters: none; width fixed at 32 bits, 32 registers.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  raw MIPS instruction.
- wb_en  in  1  writeback strobe from downstream.
- wb_addr  in  5  writeback register index.
- wb_data  in  32  writeback value.
- out_valid  out  1  issued instruction valid toward ALU.
- out_ready  in  1  downstream consumes out_* this cycle.
- out_instr  out  32  in_instr with [25:21]=5'd0, [20:16]=5'd1, all other bits unchanged.
- out_regA  out  32  value of RF[rs] at issue.
- out_regB  out  32  value of RF[rt] at issue.
- out_dest  out  5  destination register index.
- out_wen  out  1  instruction writes out_dest.

## Operation

- Decode: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0].
- Destination:
  - opcode 000000 writes rd.
  - addi/addiu/andi/ori/slti/sltiu/xori/lw (001000/001001/001100/001101/001010/001011/001110/100011) write rt.
  - beq/bne/sw (000100/000101/101011) and all other opcodes: out_wen=0, out_dest=0.
  - Destination 0: out_wen=0.
- Sources checked for hazard:
  - rs always.
  - rt for opcode 000000, beq, bne, sw.
- Register 0: reads 0, never pending, writes ignored.
- Writeback: wb_en && wb_addr!=0 writes RF[wb_addr] at clock edge and clears pending[wb_addr].
- Bypass: source s with wb_en && wb_addr==s && s!=0 reads wb_data combinationally and is treated as not pending.
- hazard = any checked source pending, or out_wen-candidate destination pending (WAW); pending bits taken after same-cycle writeback clear.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready):
  - Load all out_* registers.
  - out_valid=1.
  - If writing, set pending[dest]; set wins over a same-cycle wb clear of that index.
- out_valid && out_ready with no accept: out_valid=0, out_* data hold last values.
- Unknown opcodes/funcs pass through unaltered except the rs/rt rewrite.

## Timing

- Reset (rst_n low, asynchronous): out_valid=0; out_instr, out_regA, out_regB, out_dest, out_wen = 0; all 32 RF entries = 0; all pending = 0. in_ready is combinational and equals 1 while reset is held.
- Latency: accept at edge N → out_* valid after edge N.
- Throughput: one instruction per cycle when out_ready=1 and no hazard.
- Writeback becomes visible through the RF the cycle after wb_en; same cycle through the bypass.
- out_* are stable while out_valid && !out_ready.
- Reset asserted mid-operation discards the in-flight instruction and scoreboard. Writebacks already retired are lost (RF cleared).

## Test plan

- Operand read and rewrite:
  - Stimulus: wb r5=0x00000007, r6=0xFFFFFFFE; then issue 0x00A63820 (add r7,r5,r6).
  - Response: next cycle out_valid=1, out_instr=0x00013820, out_regA=0x00000007, out_regB=0xFFFFFFFE, out_dest=7, out_wen=1; pending[7]=1.
- RAW stall and bypass:
  - Stimulus: immediately offer 0x20E80001 (addi r8,r7,1).
  - Response: in_ready=0 for 3 idle cycles. In the cycle wb r7=0x00000005 arrives, in_ready=1. Next cycle out_regA=0x00000005, out_dest=8, out_instr=0x20010001.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles with in_valid=1.
  - Response: out_* unchanged and in_ready=0 throughout. Raising out_ready accepts the waiting instruction on that same edge.
- Register 0:
  - Stimulus: wb r0=0xDEADBEEF; then issue ori r0,r0,0x1234 (0x34001234).
  - Response: out_regA=0, out_wen=0, pending unchanged; a following read of r0 returns 0.
- Non-writing ops:
  - Stimulus: with r9 pending, issue sw r9,4(r2) (0xAC490004).
  - Response: stalls until r9 writeback; then out_wen=0, out_dest=0.
- Async reset mid-flight:
  - Stimulus: drop rst_n between clock edges while out_valid=1 and pending[7]=1.
  - Response: out_valid=0 and all out_* = 0 immediately. After release, r7 reads 0 and an instruction sourcing r7 is accepted without stall.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Handshake, writeback and issue bundle for the operand fetch stage.
// The stage is the slave; the upstream/downstream driver is the master.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_regA;
  logic [31:0] out_regB;
  logic [4:0]  out_dest;
  logic        out_wen;

  modport master (
    output in_valid, in_instr,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_regA, out_regB,
    input  out_dest, out_wen
  );

  modport slave (
    input  in_valid, in_instr,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid,
    output out_instr, out_regA, out_regB,
    output out_dest, out_wen
  );
endinterface

// File: rtl/operand_fetch.sv
// MIPS operand fetch / issue stage: register file, scoreboard,
// hazard stall and registered operand hand-off to the ALU.
module operand_fetch (
  input logic          clk,
  input logic          rst_n,
  operand_fetch_if.slave io
);

  logic [31:0] rf [32];
  logic [31:0] pending;
  logic [31:0] pend_eff;
  logic [31:0] wb_mask;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        is_imm;
  logic        is_brs;
  logic        wr_rd;
  logic        wr_rt;
  logic        chk_rt;
  logic [4:0]  dest;
  logic        wen;
  logic        hazard;
  logic        accept;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [31:0] rw_instr;

  assign op = io.in_instr[31:26];
  assign rs = io.in_instr[25:21];
  assign rt = io.in_instr[20:16];
  assign rd = io.in_instr[15:11];

  always_comb begin
    is_imm = 1'b0;
    case (op)
      6'b001000, 6'b001001, 6'b001100,
      6'b001101, 6'b001010, 6'b001011,
      6'b001110, 6'b100011: is_imm = 1'b1;
      default:              is_imm = 1'b0;
    endcase
    is_brs = (op == 6'b000100) ||
             (op == 6'b000101) ||
             (op == 6'b101011);
  end

  always_comb begin
    wr_rd  = 1'b0;
    wr_rt  = 1'b0;
    chk_rt = 1'b0;
    unique case (1'b1)
      (op == 6'b000000): begin
        wr_rd  = 1'b1;
        chk_rt = 1'b1;
      end
      is_imm: wr_rt  = 1'b1;
      is_brs: chk_rt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dest = 5'd0;
    if (wr_rd)
      dest = rd;
    else if (wr_rt)
      dest = rt;
    wen = (wr_rd || wr_rt) && (dest != 5'd0);
  end

  // Same-cycle writeback clears its pending bit before hazard check
  always_comb begin
    wb_mask = 32'd0;
    if (io.wb_en && io.wb_addr != 5'd0)
      wb_mask = 32'd1 << io.wb_addr;
    pend_eff = pending & ~wb_mask;
  end

  always_comb begin
    hazard = pend_eff[rs] ||
             (chk_rt && pend_eff[rt]) ||
             (wen && pend_eff[dest]);
  end

  assign io.in_ready = !hazard &&
                       (!io.out_valid || io.out_ready);
  assign accept = io.in_valid && io.in_ready;

  always_comb begin
    rd_a = rf[rs];
    if (rs == 5'd0)
      rd_a = 32'd0;
    else if (io.wb_en && io.wb_addr == rs)
      rd_a = io.wb_data;
    rd_b = rf[rt];
    if (rt == 5'd0)
      rd_b = 32'd0;
    else if (io.wb_en && io.wb_addr == rt)
      rd_b = io.wb_data;
  end

  always_comb begin
    rw_instr = io.in_instr;
    rw_instr[25:21] = 5'd0;
    rw_instr[20:16] = 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= 32'd0;
    end else if (io.wb_en && io.wb_addr != 5'd0) begin
      rf[io.wb_addr] <= io.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 32'd0;
    end else if (accept && wen) begin
      pending <= pend_eff | (32'd1 << dest);
    end else begin
      pending <= pend_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_instr <= 32'd0;
      io.out_regA  <= 32'd0;
      io.out_regB  <= 32'd0;
      io.out_dest  <= 5'd0;
      io.out_wen   <= 1'b0;
    end else if (accept) begin
      io.out_valid <= 1'b1;
      io.out_instr <= rw_instr;
      io.out_regA  <= rd_a;
      io.out_regB  <= rd_b;
      io.out_dest  <= dest;
      io.out_wen   <= wen;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end

endmodule
